// File: rtl/seq_det_ctrl.sv
// seq_det_ctrl
//
// Programmable serial pattern-match controller. A pattern of 1..PAT_W bits,
// a match mode and a match-count threshold are loaded from the control side.
// Detection is then armed with start. Every valid-qualified serial bit is
// shifted into a history register and compared against the pattern. Matches
// are counted. When the count reaches the threshold, a sticky done flag is
// raised and the run ends.
//
// Optional feature macro: SEQ_DET_CTRL_TIMEOUT_EN
//   When defined, the cfg_to input and the timeout output are added. A
//   counter of accepted non-matching bits then ends the run once it reaches
//   cfg_to.
//
// Ports
//   clk, rst_n     clock; asynchronous active-low reset
//   cfg_we         configuration write strobe (honoured in IDLE/DONE only)
//   cfg_pat        pattern; bit [len-1] is the first bit expected
//   cfg_len        pattern length, 1..PAT_W (other values drop the write)
//   cfg_ovl        1 = overlapping detection, 0 = non-overlapping
//   cfg_thresh     match count that ends the run; 0 = run until abort
//   cfg_to         timeout limit in accepted bits (macro only)
//   start, abort   arm / disarm detection
//   x_valid, x     serial bit qualifier and serial bit
//   busy           high while armed
//   match          one-cycle pulse per detected match
//   match_cnt      matches since last start (saturating)
//   timeout        sticky; run ended by timeout (macro only)
//   done           sticky; run ended by threshold or timeout
module seq_det_ctrl #(
    parameter int PAT_W = 8,
    parameter int CNT_W = 8,
    parameter int TO_W  = 12
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cfg_we,
    input  logic [PAT_W-1:0]       cfg_pat,
    input  logic [$clog2(PAT_W):0] cfg_len,
    input  logic                   cfg_ovl,
    input  logic [CNT_W-1:0]       cfg_thresh,
`ifdef SEQ_DET_CTRL_TIMEOUT_EN
    input  logic [TO_W-1:0]        cfg_to,
`endif
    input  logic                   start,
    input  logic                   abort,
    input  logic                   x_valid,
    input  logic                   x,
    output logic                   busy,
    output logic                   match,
    output logic [CNT_W-1:0]       match_cnt,
`ifdef SEQ_DET_CTRL_TIMEOUT_EN
    output logic                   timeout,
`endif
    output logic                   done
);

    localparam int LEN_W = $clog2(PAT_W) + 1;

    // The history shift needs at least two bits, and the counters need a
    // real width.
    if (PAT_W < 2 || CNT_W < 1 || TO_W < 1) begin : gBadParams
        $error("seq_det_ctrl: PAT_W must be >= 2, CNT_W and TO_W >= 1");
    end

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        DONE
    } state_t;

    state_t           state_q;
    logic [PAT_W-1:0] pat_q;
    logic [LEN_W-1:0] len_q;
    logic             ovl_q;
    logic [CNT_W-1:0] thresh_q;
    logic [PAT_W-1:0] hist_q;
    logic [LEN_W-1:0] fill_q;
    logic             match_q;
    logic [CNT_W-1:0] cnt_q;
    logic             done_q;

    logic [PAT_W-1:0] hist_d;
    logic [LEN_W-1:0] fill_d;
    logic [CNT_W-1:0] cnt_d;
    logic [PAT_W-1:0] lenMask;
    logic             patHit;
    logic             cfgLegal;

`ifdef SEQ_DET_CTRL_TIMEOUT_EN
    logic [TO_W-1:0]  to_q;
    logic [TO_W-1:0]  toCnt_q;
    logic [TO_W-1:0]  toCnt_d;
    logic             timeout_q;
`endif

    // These are the next-state candidates for one accepted bit. The shifted
    // history, the fill level and the saturated count are computed here. A
    // match needs a full window and equality on the low len bits only.
    always_comb begin
        hist_d  = {hist_q[PAT_W-2:0], x};
        fill_d  = (fill_q >= len_q) ? len_q : fill_q + 1'b1;
        cnt_d   = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;
        lenMask = '0;
        for (int i = 0; i < PAT_W; i++) begin
            lenMask[i] = (i < int'(len_q));
        end
        patHit   = (fill_d == len_q) && (((hist_d ^ pat_q) & lenMask) == '0);
        cfgLegal = (cfg_len != '0) && (cfg_len <= LEN_W'(PAT_W));
`ifdef SEQ_DET_CTRL_TIMEOUT_EN
        toCnt_d  = toCnt_q + 1'b1;
`endif
    end

    // Control FSM with registered outputs. The configuration is written only
    // while not armed, so a run always sees a stable pattern. A config write
    // that arrives with start lands on the same edge, before the first bit
    // can be accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pat_q     <= PAT_W'(4'b1010);
            len_q     <= LEN_W'(4);
            ovl_q     <= 1'b1;
            thresh_q  <= CNT_W'(1);
            hist_q    <= '0;
            fill_q    <= '0;
            match_q   <= 1'b0;
            cnt_q     <= '0;
            done_q    <= 1'b0;
`ifdef SEQ_DET_CTRL_TIMEOUT_EN
            to_q      <= '1;
            toCnt_q   <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            match_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (cfg_we && cfgLegal) begin
                        pat_q    <= cfg_pat;
                        len_q    <= cfg_len;
                        ovl_q    <= cfg_ovl;
                        thresh_q <= cfg_thresh;
`ifdef SEQ_DET_CTRL_TIMEOUT_EN
                        to_q     <= cfg_to;
`endif
                    end
                    if (start) begin
                        state_q   <= ARMED;
                        hist_q    <= '0;
                        fill_q    <= '0;
                        cnt_q     <= '0;
                        done_q    <= 1'b0;
`ifdef SEQ_DET_CTRL_TIMEOUT_EN
                        toCnt_q   <= '0;
                        timeout_q <= 1'b0;
`endif
                    end
                end
                ARMED: begin
                    if (abort) begin
                        state_q <= IDLE;
                    end else if (x_valid) begin
                        hist_q <= hist_d;
                        if (patHit) begin
                            match_q <= 1'b1;
                            cnt_q   <= cnt_d;
                            // Non-overlap mode needs a fresh full window
                            // before the next match can fire.
                            fill_q  <= ovl_q ? fill_d : '0;
`ifdef SEQ_DET_CTRL_TIMEOUT_EN
                            toCnt_q <= '0;
`endif
                            if (thresh_q != '0 && cnt_d == thresh_q) begin
                                state_q <= DONE;
                                done_q  <= 1'b1;
                            end
                        end else begin
                            fill_q  <= fill_d;
`ifdef SEQ_DET_CTRL_TIMEOUT_EN
                            toCnt_q <= toCnt_d;
                            if (toCnt_d == to_q) begin
                                state_q   <= DONE;
                                done_q    <= 1'b1;
                                timeout_q <= 1'b1;
                            end
`endif
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy      = (state_q == ARMED);
    assign match     = match_q;
    assign match_cnt = cnt_q;
    assign done      = done_q;
`ifdef SEQ_DET_CTRL_TIMEOUT_EN
    assign timeout   = timeout_q;
`endif

endmodule

// File: doc/seq_det_ctrl.md
# seq_det_ctrl

Programmable serial pattern-match controller for the sequence-detector family. Holds a runtime-loaded pattern (1..PAT_W bits) and match mode, arms and disarms detection on command, and counts matches on a valid-qualified serial bit stream. When the configured count is reached it raises a sticky done flag. Sits between the control/CSR side, which configures and starts it, and the serial input lane.

## Interface
- PAT_W, 8, maximum pattern length in bits
- CNT_W, 8, width of match counter and threshold
- TO_W, 12, width of timeout counter (used only with SEQ_DET_CTRL_TIMEOUT_EN)

Ports (reset rst_n, asynchronous, active-low; clock clk):
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cfg_we  in  1  configuration write strobe
- cfg_pat  in  PAT_W  pattern; bit [len-1] is the first bit expected
- cfg_len  in  $clog2(PAT_W)+1  pattern length, legal values 1..PAT_W
- cfg_ovl  in  1  1 = overlapping detection, 0 = non-overlapping
- cfg_thresh  in  CNT_W  match count that ends the run; 0 = run until abort
- cfg_to  in  TO_W  timeout limit in accepted bits (macro only)
- start  in  1  arm detection
- abort  in  1  disarm detection
- x_valid  in  1  serial bit qualifier
- x  in  1  serial bit
- busy  out  1  high while ARMED
- match  out  1  one-cycle pulse per detected match
- match_cnt  out  CNT_W  matches since last start
- done  out  1  sticky; threshold reached or timeout
- timeout  out  1  sticky; run ended by timeout (macro only)

## Operation
- States: IDLE, ARMED, DONE. Reset → IDLE.
- Reset values: busy=0, match=0, match_cnt=0, done=0, timeout=0, hist=0, fill=0.
- Reset configuration: pat=0b1010, len=4, ovl=1, thresh=1, to=all ones.
- cfg_we is accepted only in IDLE or DONE. In ARMED it is ignored.
- cfg_we with cfg_len=0 or cfg_len>PAT_W is ignored entirely; all config registers keep their old values.
- IDLE or DONE with start=1: clear hist, fill, match_cnt, done, and timeout, then go to ARMED. If cfg_we and start arrive in the same cycle, the new configuration applies to this run.
- ARMED with abort=1 → IDLE. match_cnt is held, done stays 0. Any bit presented that cycle is discarded. abort has priority over start and x_valid. abort in IDLE or DONE has no effect.
- start in ARMED is ignored.
- Each accepted bit (ARMED and x_valid) does the following:
  - hist = {hist[PAT_W-2:0], x}.
  - fill = min(fill+1, len).
  - Match is true when the new fill == len and the new hist[len-1:0] == pat[len-1:0].
- On a match:
  - match pulses and match_cnt increments, saturating at all ones.
  - Overlap mode: fill is unchanged.
  - Non-overlap mode: fill is cleared to 0.
- If match_cnt reaches thresh (thresh≠0), go to DONE and set done. From then on bits are ignored until the next start.
- x_valid outside ARMED is ignored.

## Timing
- match, match_cnt, done, and the state change all update on the clock edge that samples the accepted bit. They are visible in the following cycle.
- match is high for exactly one cycle per match. Back-to-back matches on consecutive valid bits give consecutive pulses.
- busy falls on the same edge that done rises.
- start → busy=1 on the next edge. The first bit can be accepted in the cycle after that.
- Minimum detection latency is len accepted bits after arming.

## Configuration
- SEQ_DET_CTRL_TIMEOUT_EN defined:
  - cfg_to and timeout ports exist, and a TO_W-bit counter is built.
  - The counter counts accepted bits in ARMED. It clears on start and on every match.
  - When the counter reaches cfg_to (on an accepted non-matching bit), go to DONE with done=1 and timeout=1.
  - If a match and timeout coincide, the match wins: the counter clears and timeout is not set.
- Not defined: no counter, and no cfg_to or timeout ports. A run ends only by threshold or abort.

## Test plan
- Overlap mode, pat 1010, len 4, thresh 0, stream 10101010 → match pulses after bits 4, 6, 8; match_cnt=3.
- Non-overlap mode, same stream → pulses after bits 4 and 8; match_cnt=2.
- Overlap, thresh 2, stream 1010101011 → done=1 and busy=0 after bit 6. Bits 7–10 produce no pulse; match_cnt stays 2.
- x_valid toggled every other cycle, invalid cycles carry x=1, len-3 pat 011 → only valid bits count; the result is identical to the gap-free run.
- Config and abort handling:
  - cfg_we with len=5 while ARMED → config unchanged.
  - abort after 1 match → IDLE, busy=0, done=0, match_cnt=1.
  - cfg_len=0 write in IDLE → ignored.
- With SEQ_DET_CTRL_TIMEOUT_EN, cfg_to=5, stream 0000000 → done=1 and timeout=1 after bit 5, with no match pulse.
